// File: rtl/seg7_pkg.sv
// seg7_pkg: shared segment table, blank pattern and default parameters for the scanned display
package seg7_pkg;
  typedef logic [6:0] seg_t;
  localparam int DEF_NUM_DIGITS = 8;
  localparam int DEF_REFRESH_DIV = 100000;
  localparam logic [63:0] DEF_INIT_VALUE = '0;
  localparam seg_t BLANK_SEG = 7'b1111111;
  // Active-low a..g, entry F first so SEG_TABLE[n] selects hex digit n
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'b0111000, 7'b0110000, 7'b1000010, 7'b0110001,
    7'b1100000, 7'b0001000, 7'b0000100, 7'b0000000,
    7'b0001111, 7'b0100000, 7'b0100100, 7'b1001100,
    7'b0000110, 7'b0010010, 7'b1001111, 7'b0000001
  };
endpackage

// File: rtl/seg7_scan_display_if.sv
// seg7_scan_display_if: control inputs and display/value outputs of the scanned display
interface seg7_scan_display_if
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = DEF_NUM_DIGITS
);
  logic load;
  logic [4*NUM_DIGITS-1:0] load_value;
  logic inc_en;
  logic disp_en;
  logic blank_lz;
  logic [NUM_DIGITS-1:0] dp_mask;
  seg_t a_to_g;
  logic [NUM_DIGITS-1:0] an;
  logic dp;
  logic [4*NUM_DIGITS-1:0] value;
  modport master (
    output load, load_value, inc_en, disp_en, blank_lz, dp_mask,
    input a_to_g, an, dp, value
  );
  modport slave (
    input load, load_value, inc_en, disp_en, blank_lz, dp_mask,
    output a_to_g, an, dp, value
  );
endinterface

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode: nibble to active-low a..g segment pattern
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output seg_t       seg
);
  assign seg = SEG_TABLE[nib];
endmodule

// File: rtl/seg7_scan_display.sv
// seg7_scan_display: time-multiplexed hex display with loadable/incrementing value register
module seg7_scan_display
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = DEF_NUM_DIGITS,
  parameter int REFRESH_DIV = DEF_REFRESH_DIV,
  parameter logic [4*NUM_DIGITS-1:0] INIT_VALUE = (4*NUM_DIGITS)'(DEF_INIT_VALUE)
) (
  input logic clk,
  input logic clr,
  seg7_scan_display_if.slave bus
);
  localparam int W = 4 * NUM_DIGITS;
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam int CW = $clog2(REFRESH_DIV);
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic [W-1:0] val;
  logic tick;
  logic blank;
  logic [NUM_DIGITS-1:0] lz;
  seg_t seg;
  assign tick = cnt == CW'(REFRESH_DIV - 1);
  assign bus.value = val;
  // lz[i]: nibbles i and above are all zero
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_lz
    assign lz[i] = ~|val[W-1:4*i];
  end
  assign blank = ~bus.disp_en | (bus.blank_lz & (idx != '0) & lz[idx]);
  seg7_hex_decode u_dec (
    .nib(val[4*idx +: 4]),
    .seg(seg)
  );
  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
      idx <= '0;
      val <= INIT_VALUE;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (tick) idx <= idx == IW'(NUM_DIGITS - 1) ? '0 : idx + 1'b1;
      val <= bus.load ? bus.load_value : bus.inc_en ? val + 1'b1 : val;
    end
  end
  // Outputs present the index/value registered on the previous edge
  always_ff @(posedge clk) begin
    if (clr) begin
      bus.an <= '1;
      bus.a_to_g <= BLANK_SEG;
      bus.dp <= 1'b1;
    end else begin
      bus.an <= blank ? '1 : ~(NUM_DIGITS'(1) << idx);
      bus.a_to_g <= blank ? BLANK_SEG : seg;
      bus.dp <= blank ? 1'b1 : ~bus.dp_mask[idx];
    end
  end
endmodule

// File: doc/seg7_scan_display.md
SEG7_SCAN_DISPLAY -- requirements
Module: seg7_scan_display

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 8: number of multiplexed digits, legal range 1..16.
REQ-002 SHALL have parameter REFRESH_DIV, default 100000: clk cycles per digit slot, legal minimum 2.
REQ-003 SHALL have parameter INIT_VALUE, default 0: value register contents after reset, width 4*NUM_DIGITS.
REQ-004 SHALL have port clk  in  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port clr  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port load  in  1  when 1, value register takes load_value.
REQ-007 SHALL have port load_value  in  4*NUM_DIGITS  value to display, nibble i = digit i.
REQ-008 SHALL have port inc_en  in  1  when 1 (and load=0), value register increments every clk.
REQ-009 SHALL have port disp_en  in  1  when 0, all digits dark.
REQ-010 SHALL have port blank_lz  in  1  when 1, leading zeros suppressed.
REQ-011 SHALL have port dp_mask  in  NUM_DIGITS  bit i = 1 lights the decimal point of digit i.
REQ-012 SHALL have port a_to_g  out  7  segments, active-low; bit6 = a ... bit0 = g.
REQ-013 SHALL have port an  out  NUM_DIGITS  digit selects, active-low, at most one bit 0.
REQ-014 SHALL have port dp  out  1  decimal point, active-low.
REQ-015 SHALL have port value  out  4*NUM_DIGITS  current value register contents.

Function
REQ-016 Prescaler SHALL count 0..REFRESH_DIV-1 and wrap to 0. A tick SHALL be asserted on the cycle the count equals REFRESH_DIV-1.
REQ-017 Digit index SHALL advance by 1 on each tick and wrap from NUM_DIGITS-1 to 0.
REQ-018 Value register update priority: load > inc_en > hold.
REQ-019 Increment SHALL wrap modulo 2^(4*NUM_DIGITS): all-F + 1 gives 0.
REQ-020 Load and inc_en SHALL be independent of the tick. Load or increment in the same cycle as a tick SHALL still take effect.
REQ-021 a_to_g, an and dp SHALL be registered.
REQ-022 Outputs SHALL reflect digit index and value register as they stand after clock edge N, one cycle after that edge (at edge N+1).
REQ-023 Hex decode, active-low: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
REQ-024 Digit i SHALL be blanked when blank_lz=1, i>0, and nibbles i..NUM_DIGITS-1 are all zero. Digit 0 SHALL never be blanked, so value 0 shows a single "0".
REQ-025 A blanked digit, or any digit while disp_en=0, SHALL drive an all 1s, a_to_g=1111111 and dp=1.
REQ-026 While disp_en=0, the prescaler and index SHALL keep running.
REQ-027 An unblanked, enabled digit i SHALL drive an bit i = 0, all other an bits 1, and dp = ~dp_mask[i].
REQ-028 The value output SHALL be the register itself, updating at the edge after load or increment.

Reset
REQ-029 clr=1 at a rising edge SHALL set prescaler=0, index=0, value=INIT_VALUE, an=all 1s, a_to_g=1111111, dp=1.
REQ-030 clr SHALL override load and inc_en.
REQ-031 clr asserted mid-scan SHALL abort the current slot. After release, scanning SHALL restart at digit 0 with a full REFRESH_DIV slot.
REQ-032 The first enabled digit-0 pattern SHALL appear on the second edge after clr deasserts.

Structure
REQ-033 Shared package seg7_pkg SHALL hold the 16-entry segment table constants, the blank pattern constant, and default parameter values.
REQ-034 The combinational nibble-to-segment decoder SHALL be sub-module seg7_hex_decode: 4-bit nibble in, 7-bit a_to_g out.
REQ-035 Prescaler, index, value register, blanking and output registers SHALL reside in seg7_scan_display.

Verification
(Bench configuration: NUM_DIGITS=4, REFRESH_DIV=4, INIT_VALUE=16'h1234.)
REQ-036 Scan: clr pulse, then disp_en=1, blank_lz=0 -> an cycles 1110, 1101, 1011, 0111, each held 4 cycles; a_to_g = 1001100, 0000110, 0010010, 1001111 (digits 4, 3, 2, 1).
REQ-037 Load/increment: load_value=16'hFFFF with load=1 for one cycle, then inc_en=1 for one cycle -> value=16'h0000; with no load/inc, value holds.
REQ-038 Load vs inc: load=1 and inc_en=1 with load_value=16'h00A0 -> value=16'h00A0, not 16'h00A1.
REQ-039 Blanking: value=16'h0000, blank_lz=1 -> only digit 0 lit, showing 0000001. With value=16'h0050, digits 1 and 0 lit, digits 3 and 2 dark.
REQ-040 dp/disable: dp_mask=4'b0100 -> dp=0 only in the digit-2 slot. With disp_en=0, an=1111 throughout and the index keeps advancing.
REQ-041 Mid-scan reset: clr pulse during the digit-2 slot -> next edge shows an=1111 and value=16'h1234; scanning resumes at digit 0.
